// File: rtl/dff_check_pkg.sv
// dff_check_pkg: shared state encoding and index width for the DFF response checker
package dff_check_pkg;
    localparam int IDX_W = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    // clear has priority; increment stops at all-ones
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dff_response_checker.sv
// dff_response_checker: compares a flip-flop's q/q_bar against the previous cycle's d
module dff_response_checker
    import dff_check_pkg::*;
#(
    parameter int NUM_SAMPLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             d_in,
    input  logic             q_in,
    input  logic             q_bar_in,
    output logic             busy,
    output logic             done,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [IDX_W-1:0] sample_cnt
);
    state_t state;
    logic   d_prev;
    logic   go;
    logic   last;
    logic   hit;

    assign go   = start && !clear && (state == IDLE || state == DONE);
    assign last = sample_cnt == IDX_W'(NUM_SAMPLES);
    assign hit  = !clear && state == CHECK && !last &&
                  ((q_in != d_prev) || (q_bar_in != ~q_in));
    assign busy = state == ARM || state == CHECK;
    assign done = state == DONE;

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (go),
        .inc  (hit),
        .cnt  (err_count)
    );

    // run sequencing: arm, compare NUM_SAMPLES cycles, one settle cycle, then hold results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            d_prev        <= 1'b0;
            err_flag      <= 1'b0;
            first_err_idx <= '0;
            sample_cnt    <= '0;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: if (start) begin
                    state         <= ARM;
                    err_flag      <= 1'b0;
                    first_err_idx <= '0;
                    sample_cnt    <= '0;
                end
                ARM: begin
                    d_prev <= d_in;
                    state  <= CHECK;
                end
                CHECK: if (last) begin
                    state <= DONE;
                end else begin
                    d_prev     <= d_in;
                    sample_cnt <= sample_cnt + 1'b1;
                    if (hit) begin
                        err_flag <= 1'b1;
                        if (!err_flag) first_err_idx <= sample_cnt;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dff_response_checker.sv
// tb_dff_response_checker: randomized/directed bench with a sample-level reference model
module tb_dff_response_checker;
    import dff_check_pkg::*;

    logic clk = 0, rst_n = 1, start = 0, clear = 0, d_in = 0, q_in = 0, q_bar_in = 1;
    logic busy_a, done_a, flag_a, busy_b, done_b, flag_b, busy_c, done_c, flag_c;
    logic [7:0]  cnt_a, cnt_b;
    logic [1:0]  cnt_c;
    logic [15:0] idx_a, sc_a, idx_b, sc_b, idx_c, sc_c;
    int   checks = 0, failures = 0;
    logic mm [64];
    logic d_last = 0;

    always #5 clk = ~clk;

    dff_response_checker #(.NUM_SAMPLES(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .d_in(d_in), .q_in(q_in),
        .q_bar_in(q_bar_in), .busy(busy_a), .done(done_a), .err_flag(flag_a),
        .err_count(cnt_a), .first_err_idx(idx_a), .sample_cnt(sc_a));
    dff_response_checker #(.NUM_SAMPLES(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .d_in(d_in), .q_in(q_in),
        .q_bar_in(q_bar_in), .busy(busy_b), .done(done_b), .err_flag(flag_b),
        .err_count(cnt_b), .first_err_idx(idx_b), .sample_cnt(sc_b));
    dff_response_checker #(.NUM_SAMPLES(16), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .d_in(d_in), .q_in(q_in),
        .q_bar_in(q_bar_in), .busy(busy_c), .done(done_c), .err_flag(flag_c),
        .err_count(cnt_c), .first_err_idx(idx_c), .sample_cnt(sc_c));

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expected results of a finished run, derived from the recorded per-sample mismatches
    task automatic check_result(string tag, int n, int w, logic flag, logic [31:0] cnt,
                                logic [31:0] idx, logic [31:0] sc);
        int c = 0;
        int first = -1;
        int lim = (1 << w) - 1;
        for (int k = 0; k < n; k++)
            if (mm[k]) begin
                c++;
                if (first < 0) first = k;
            end
        chk({tag, ".flag"}, {31'd0, flag}, {31'd0, c > 0});
        chk({tag, ".count"}, cnt, c > lim ? lim : c);
        chk({tag, ".first"}, idx, first < 0 ? 0 : first);
        chk({tag, ".samples"}, sc, n);
    endtask

    // inputs for edge e; q/q_bar model a flip-flop (optionally faulty) fed by the previous d
    task automatic drive(int e, int mode);
        logic d, q, qb;
        int k = e - 2;
        d  = (mode <= 2) ? 1'((e - 1) & 1) : 1'($urandom_range(0, 1));
        q  = d_last;
        if (e >= 2 && mode == 1 && k >= 5) q = 1'b0;
        if (e >= 2 && mode == 3) q = !d_last;
        qb = !q;
        if (e >= 2 && mode == 2) qb = q;
        if (e >= 2 && mode == 4 && $urandom_range(0, 3) == 0) begin
            q  = 1'($urandom_range(0, 1));
            qb = 1'($urandom_range(0, 1));
        end
        if (e >= 2) mm[k] = (q != d_last) || (qb != !q);
        d_in = d; q_in = q; q_bar_in = qb; d_last = d;
    endtask

    task automatic run(string tag, int mode, int clr_edge);
        for (int k = 0; k < 64; k++) mm[k] = 1'b0;
        @(negedge clk); drive(0, mode); start = 1; clear = 0;
        @(posedge clk);
        for (int e = 1; e <= 19; e++) begin
            @(negedge clk);
            drive(e, mode);
            start = (mode == 4 && e >= 2 && e <= 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            clear = (e == clr_edge);
            @(posedge clk); #1;
            if (e == clr_edge) begin
                chk({tag, ".clr_busy"}, {31'd0, busy_a}, 0);
                chk({tag, ".clr_samples"}, sc_a, e - 2);
                chk({tag, ".clr_done_b"}, {31'd0, done_b}, 0);
                chk({tag, ".clr_samples_b"}, sc_b, 4);
                @(negedge clk); clear = 0;
                return;
            end
            if (e == 1) chk({tag, ".busy_arm"}, {31'd0, busy_a}, 1);
            if (e == 5) chk({tag, ".done_b_early"}, {31'd0, done_b}, 0);
            if (e == 6) chk({tag, ".done_b"}, {31'd0, done_b}, 1);
            if (e == 17) chk({tag, ".done_a_early"}, {31'd0, done_a}, 0);
            if (e == 18) chk({tag, ".done_a"}, {31'd0, done_a}, 1);
            if (e == 18) chk({tag, ".done_c"}, {31'd0, done_c}, 1);
        end
        check_result({tag, ".a"}, 16, 8, flag_a, cnt_a, idx_a, sc_a);
        check_result({tag, ".b"}, 4, 8, flag_b, cnt_b, idx_b, sc_b);
        check_result({tag, ".c"}, 16, 2, flag_c, cnt_c, idx_c, sc_c);
    endtask

    initial begin
        #2 rst_n = 0;
        #1;
        chk("rst.busy", {31'd0, busy_a}, 0);
        chk("rst.done", {31'd0, done_a}, 0);
        chk("rst.flag", {31'd0, flag_a}, 0);
        chk("rst.count", cnt_a, 0);
        chk("rst.samples", sc_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        run("good", 0, -1);
        run("stuck0", 1, -1);
        run("qbar_eq_q", 2, -1);
        run("inverted", 3, -1);
        for (int i = 0; i < 3; i++) run("random", 4, -1);
        run("clear", 0, 9);
        @(negedge clk); start = 1; clear = 1;
        @(posedge clk); #1;
        chk("clear_start.busy", {31'd0, busy_a}, 0);
        chk("clear_start.samples", sc_a, 7);
        @(negedge clk); start = 0; clear = 0;
        run("restart", 0, -1);
        @(negedge clk); drive(0, 0); start = 1;
        @(posedge clk);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk); drive(e, 0); start = 0;
            @(posedge clk);
        end
        #2 rst_n = 0;
        #1;
        chk("midrst.busy", {31'd0, busy_a}, 0);
        chk("midrst.done", {31'd0, done_a}, 0);
        chk("midrst.flag", {31'd0, flag_a}, 0);
        chk("midrst.count", cnt_a, 0);
        chk("midrst.first", idx_a, 0);
        chk("midrst.samples", sc_a, 0);
        @(negedge clk); rst_n = 1;
        repeat (3) @(posedge clk);
        #1 chk("midrst.idle", {31'd0, busy_a}, 0);
        run("after_rst", 0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dff_response_checker.md
DFF_RESPONSE_CHECKER -- requirements
Module: dff_response_checker

Interface
REQ-001 Parameter NUM_SAMPLES, default 16, SHALL give the number of compared cycles per run (legal range 1..65535).
REQ-002 Parameter CNT_W, default 8, SHALL give the error-counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle run request.
REQ-006 clear  input  1  SHALL be a synchronous abort back to IDLE.
REQ-007 d_in  input  1  SHALL be the data bit driven into the flip-flop under check.
REQ-008 q_in  input  1  SHALL be the flip-flop q output.
REQ-009 q_bar_in  input  1  SHALL be the flip-flop q_bar output.
REQ-010 busy  output  1  SHALL be high in ARM and CHECK.
REQ-011 done  output  1  SHALL be high in DONE.
REQ-012 err_flag  output  1  SHALL be high once any mismatch is seen in the current run.
REQ-013 err_count  output  CNT_W  SHALL count mismatching cycles, saturating at all-ones.
REQ-014 first_err_idx  output  16  SHALL hold the sample index of the first mismatch.
REQ-015 sample_cnt  output  16  SHALL count cycles compared so far.

Function
REQ-016 FSM states SHALL be IDLE, ARM, CHECK, DONE.
REQ-017 IDLE: start SHALL move to ARM and clear err_flag, err_count, first_err_idx, sample_cnt.
REQ-018 ARM (one cycle): d_prev SHALL capture d_in; no comparison; next state CHECK.
REQ-019 CHECK, each cycle: expected = d_prev; mismatch = (q_in != d_prev) OR (q_bar_in != ~q_in).
REQ-020 CHECK, each cycle: d_prev <= d_in and sample_cnt <= sample_cnt + 1.
REQ-021 On mismatch, err_count SHALL increment unless all-ones; err_flag SHALL set.
REQ-022 On the first mismatch of a run, first_err_idx SHALL take the current sample_cnt (pre-increment); later mismatches leave it unchanged.
REQ-023 When the compared cycle has sample_cnt == NUM_SAMPLES-1, the FSM SHALL go to DONE next cycle, sample_cnt ending at NUM_SAMPLES.
REQ-024 DONE: outputs SHALL hold; start SHALL re-enter ARM with the REQ-017 clears.
REQ-025 start in ARM or CHECK SHALL be ignored.
REQ-026 clear SHALL force IDLE from any state next cycle without changing result outputs; clear with start simultaneous: clear wins.
REQ-027 Latency: done SHALL rise exactly NUM_SAMPLES+2 cycles after the start-sampling edge.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, d_prev=0, busy=0, done=0, err_flag=0, err_count=0, first_err_idx=0, sample_cnt=0.
REQ-029 Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start.

Structure
REQ-030 State encoding (IDLE=0, ARM=1, CHECK=2, DONE=3) and the 16-bit index width SHALL live in a shared package dff_check_pkg.
REQ-031 One sub-module, sat_counter (parameterised width, increment, synchronous clear, saturating), SHALL implement err_count.
REQ-032 The checker SHALL be usable inside the existing D flip-flop bench alongside the d_flipflop instance, with no changes to that instance.

Verification
REQ-033 Good DFF, d sequence 0,1,0,1,... with NUM_SAMPLES=16 -> done after 18 cycles, err_flag=0, err_count=0, sample_cnt=16.
REQ-034 q_in forced to 0 from sample 5 onward with alternating d -> err_flag=1, first_err_idx=5, err_count=6 (odd samples 5..15, where expected=1).
REQ-035 q_bar_in tied equal to q_in, NUM_SAMPLES=4 -> err_count=4, first_err_idx=0.
REQ-036 CNT_W=2 with q_in stuck at ~d_prev for 16 samples -> err_count saturates at 3.
REQ-037 clear at sample 7 then start -> IDLE next cycle, counters reset on restart, second run completes with done after 18 cycles.
REQ-038 rst_n low during CHECK -> all outputs 0 asynchronously; start after release -> normal run.
